aes128_round_sequencer: RTL and testbench

AES128_ROUND_SEQUENCER -- requirements
Module: aes128_round_sequencer

---
 rtl/aes128_round_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_aes128_round_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sequencer.sv
// AES-128 round sequencer: issues SubBytes/ShiftRows/MixColumn/AddRoundKey starts in cipher order.
// Define AES128_SEQ_TIMEOUT_EN to enable the sub-block wait timeout (error_o).

package aes128_seq_pkg;
  typedef enum logic {
    ModeEncrypt = 1'b0,
    ModeDecrypt = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    StepSb  = 2'd0,
    StepSr  = 2'd1,
    StepMc  = 2'd2,
    StepArk = 2'd3
  } step_e;
endpackage

module aes128_round_sequencer
  import aes128_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  mode_t      mode_i,
  output logic       sb_start_o,
  output logic       sr_start_o,
  output logic       mc_start_o,
  output logic       ark_start_o,
  input  logic       sb_done_i,
  input  logic       sr_done_i,
  input  logic       mc_done_i,
  input  logic       ark_done_i,
  output mode_t      mode_o,
  output logic [3:0] round_o,
  output logic [3:0] key_idx_o,
  output logic [1:0] step_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFinish
  } state_e;

  state_e     state_q, state_d;
  mode_t      mode_q, mode_d;
  logic [3:0] round_q, round_d;
  step_e      step_q, step_d;

  logic       is_dec;
  logic       last_round;
  logic       last_step;
  logic       final_step;
  step_e      step_next;
  logic [3:0] round_next;
  logic [3:0] done_vec;
  logic       step_done;
  logic       timeout_hit;

  assign is_dec     = (mode_q == ModeDecrypt);
  assign last_round = (round_q == 4'd10);
  assign final_step = last_round && (step_q == StepArk);
  assign done_vec   = {ark_done_i, mc_done_i, sr_done_i, sb_done_i};
  assign step_done  = done_vec[step_q];

  // Round 0 and round 10 end on ARK; decrypt middle rounds end on MC.
  always_comb begin
    last_step  = 1'b0;
    step_next  = StepArk;
    round_next = round_q;
    if ((round_q == 4'd0) || last_round) begin
      last_step = (step_q == StepArk);
    end else begin
      last_step = is_dec ? (step_q == StepMc) : (step_q == StepArk);
    end
    case (step_q)
      StepSb:  step_next = is_dec ? StepArk : StepSr;
      StepSr:  step_next = is_dec ? StepSb : (last_round ? StepArk : StepMc);
      StepMc:  step_next = StepArk;
      StepArk: step_next = StepMc;
      default: step_next = StepArk;
    endcase
    if (last_step) begin
      step_next  = is_dec ? StepSr : StepSb;
      round_next = round_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    round_d = round_q;
    step_d  = step_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          round_d = 4'd0;
          step_d  = StepArk;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (step_done) begin
          if (final_step) begin
            state_d = StFinish;
          end else begin
            state_d = StIssue;
            step_d  = step_next;
            round_d = round_next;
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort beats a coincident done: the step does not advance.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      round_d = round_q;
      step_d  = step_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      mode_q  <= ModeEncrypt;
      round_q <= 4'd0;
      step_q  <= StepArk;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      step_q  <= step_d;
    end
  end

`ifdef AES128_SEQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero on the first WAIT cycle, so hitting TimeoutLast means TIMEOUT_CYCLES waited.
  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == TimeoutLast);
  assign wait_cnt_d  = (state_q == StWait) ? (wait_cnt_q + 8'd1) : 8'd0;
  assign error_o     = timeout_hit && !step_done && !abort_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign error_o        = 1'b0;
`endif

  logic issue;

  assign issue       = (state_q == StIssue) && !abort_i;
  assign sb_start_o  = issue && (step_q == StepSb);
  assign sr_start_o  = issue && (step_q == StepSr);
  assign mc_start_o  = issue && (step_q == StepMc);
  assign ark_start_o = issue && (step_q == StepArk);
  assign done_o      = (state_q == StFinish) && !abort_i;
  assign busy_o      = (state_q != StIdle);
  assign mode_o      = mode_q;
  assign round_o     = round_q;
  assign step_o      = step_q;
  assign key_idx_o   = is_dec ? (4'd10 - round_q) : round_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer: stub sub-blocks plus a step scoreboard.
// Exercises the timeout path when AES128_SEQ_TIMEOUT_EN is defined.

module tb_aes128_round_sequencer;
  import aes128_seq_pkg::*;

  localparam int unsigned TimeoutCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       start_i;
  logic       abort_i;
  mode_t      mode_i;
  logic       sb_start_o, sr_start_o, mc_start_o, ark_start_o;
  logic       sb_done_i, sr_done_i, mc_done_i, ark_done_i;
  mode_t      mode_o;
  logic [3:0] round_o;
  logic [3:0] key_idx_o;
  logic [1:0] step_o;
  logic       busy_o, done_o, error_o;

  always #5 clk = ~clk;

  aes128_round_sequencer #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) u_dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .mode_i     (mode_i),
    .sb_start_o (sb_start_o),
    .sr_start_o (sr_start_o),
    .mc_start_o (mc_start_o),
    .ark_start_o(ark_start_o),
    .sb_done_i  (sb_done_i),
    .sr_done_i  (sr_done_i),
    .mc_done_i  (mc_done_i),
    .ark_done_i (ark_done_i),
    .mode_o     (mode_o),
    .round_o    (round_o),
    .key_idx_o  (key_idx_o),
    .step_o     (step_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Sub-block stubs: done pulses lat[b] cycles after the start pulse is sampled.
  logic [3:0] en = 4'hF;
  int         lat [4] = '{1, 1, 1, 1};
  int         cnt [4] = '{0, 0, 0, 0};
  logic [3:0] stub_done = 4'h0;
  logic [3:0] stray_force;
  logic       inj_en;
  logic       stray_mc;
  logic [3:0] st;

  assign st = {ark_start_o, mc_start_o, sr_start_o, sb_start_o};

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      stub_done[b] <= 1'b0;
      if (st[b] && en[b]) begin
        if (lat[b] == 1) stub_done[b] <= 1'b1;
        else cnt[b] <= lat[b] - 1;
      end else if (cnt[b] > 0) begin
        cnt[b] <= cnt[b] - 1;
        if (cnt[b] == 1) stub_done[b] <= 1'b1;
      end
    end
  end

  // Non-matching dones injected while the DUT waits on MixColumn.
  assign stray_mc   = inj_en && busy_o && (step_o == 2'd2) && !mc_start_o;
  assign sb_done_i  = stub_done[0] | stray_force[0] | stray_mc;
  assign sr_done_i  = stub_done[1] | stray_force[1] | stray_mc;
  assign mc_done_i  = stub_done[2] | stray_force[2];
  assign ark_done_i = stub_done[3] | stray_force[3] | stray_mc;

  typedef struct {
    int step;
    int round;
    int key;
    int mode;
  } exp_t;

  exp_t sbq[$];

  task automatic push_seq(input mode_t m);
    int   mid  [4];
    int   last [3];
    int   dec;
    exp_t e;
    dec = (m == ModeDecrypt) ? 1 : 0;
    if (dec == 1) begin
      mid  = '{1, 0, 3, 2};
      last = '{1, 0, 3};
    end else begin
      mid  = '{0, 1, 2, 3};
      last = '{0, 1, 3};
    end
    e = '{3, 0, dec ? 10 : 0, dec};
    sbq.push_back(e);
    for (int r = 1; r <= 9; r++) begin
      for (int i = 0; i < 4; i++) begin
        e = '{mid[i], r, dec ? 10 - r : r, dec};
        sbq.push_back(e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = '{last[i], 10, dec ? 0 : 10, dec};
      sbq.push_back(e);
    end
  endtask

  int   blk_cnt [4] = '{0, 0, 0, 0};
  int   total_starts = 0;
  logic err_seen = 1'b0;

  always @(negedge clk) begin
    logic [3:0] hot;
    int         step_seen;
    exp_t       e;
    hot = st;
    err_seen <= err_seen | error_o;
    if (hot != 4'h0) begin
      chk("start_onehot", $countones(hot), 1);
      total_starts <= total_starts + 1;
      step_seen = 0;
      for (int b = 0; b < 4; b++) begin
        if (hot[b]) begin
          blk_cnt[b] <= blk_cnt[b] + 1;
          step_seen = b;
        end
      end
      chk("start_expected", (sbq.size() > 0) ? 1 : 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("step", step_seen, e.step);
        chk("round", int'(round_o), e.round);
        chk("key_idx", int'(key_idx_o), e.key);
        chk("mode", int'(mode_o), e.mode);
      end
    end
  end

  task automatic check_rst(input string p);
    chk({p, "_busy"}, int'(busy_o), 0);
    chk({p, "_done"}, int'(done_o), 0);
    chk({p, "_error"}, int'(error_o), 0);
    chk({p, "_starts"}, int'(st), 0);
    chk({p, "_round"}, int'(round_o), 0);
    chk({p, "_key_idx"}, int'(key_idx_o), 0);
    chk({p, "_step"}, int'(step_o), 3);
    chk({p, "_mode"}, int'(mode_o), 0);
  endtask

  task automatic kick(input mode_t m);
    @(negedge clk);
    mode_i  = m;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic run_op(input mode_t m, input int exp_done, input string tag);
    int base [4];
    int done_at;
    sbq.delete();
    push_seq(m);
    for (int b = 0; b < 4; b++) base[b] = blk_cnt[b];
    kick(m);
    mode_i  = (m == ModeEncrypt) ? ModeDecrypt : ModeEncrypt;
    done_at = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      start_i = (n == 21);
      if (done_o) begin
        done_at = n;
        break;
      end
    end
    start_i = 1'b0;
    chk({tag, "_done_cycle"}, done_at, exp_done);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done_o), 0);
    chk({tag, "_idle"}, int'(busy_o), 0);
    chk({tag, "_final_round"}, int'(round_o), 10);
    chk({tag, "_final_step"}, int'(step_o), 3);
    chk({tag, "_sb_cnt"}, blk_cnt[0] - base[0], 10);
    chk({tag, "_sr_cnt"}, blk_cnt[1] - base[1], 10);
    chk({tag, "_mc_cnt"}, blk_cnt[2] - base[2], 9);
    chk({tag, "_ark_cnt"}, blk_cnt[3] - base[3], 11);
    chk({tag, "_sb_left"}, sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int t0;
    int dseen;
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    mode_i      = ModeEncrypt;
    stray_force = 4'h0;
    inj_en      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst("por");
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("rel_starts", int'(st), 0);
    chk("rel_busy", int'(busy_o), 0);

    run_op(ModeEncrypt, 81, "enc");
    run_op(ModeDecrypt, 81, "dec");

    lat[2] = 65;
    inj_en = 1'b1;
    run_op(ModeEncrypt, 657, "enc_mclat");
    lat[2] = 1;
    inj_en = 1'b0;

    // Abort coincident with the round-5 MixColumn done.
    sbq.delete();
    push_seq(ModeEncrypt);
    kick(ModeEncrypt);
    found = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (mc_done_i && (round_o == 4'd5)) begin
        found = 1;
        break;
      end
    end
    chk("abort_reached", found, 1);
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    sbq.delete();
    t0 = total_starts;
    @(negedge clk);
    chk("abort_idle", int'(busy_o), 0);
    dseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o) dseen = 1;
    end
    chk("abort_no_starts", total_starts - t0, 0);
    chk("abort_no_done", dseen, 0);

    // Mid-operation reset in round 3 of a decrypt.
    sbq.delete();
    push_seq(ModeDecrypt);
    kick(ModeDecrypt);
    found = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (round_o == 4'd3) begin
        found = 1;
        break;
      end
    end
    chk("rst_reached", found, 1);
    rst_n_i = 1'b0;
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    sbq.delete();
    @(negedge clk);
    check_rst("midrst");
    stray_force = 4'hF;
    @(negedge clk);
    stray_force = 4'h0;
    chk("stray_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("stray_busy2", int'(busy_o), 0);
    chk("stray_starts", int'(st), 0);
    run_op(ModeDecrypt, 81, "dec_after_rst");

`ifdef AES128_SEQ_TIMEOUT_EN
    en[0] = 1'b0;
    sbq.delete();
    push_seq(ModeEncrypt);
    kick(ModeEncrypt);
    found = -1;
    dseen = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done_o) dseen = 1;
      if (error_o) begin
        found = n;
        break;
      end
    end
    chk("timeout_cycle", found, 19);
    @(negedge clk);
    chk("timeout_pulse", int'(error_o), 0);
    chk("timeout_idle", int'(busy_o), 0);
    chk("timeout_no_done", dseen, 0);
    en[0] = 1'b1;
    run_op(ModeEncrypt, 81, "after_timeout");
`else
    chk("error_never", int'(err_seen), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
